// File: rtl/instruction_fetch.sv
// Instruction fetch unit: word-addressed PC with BOOT/RUN/HALTED sequencing and
// prioritised redirects (stall > halt > jr > jump > taken branch > sequential).
module instruction_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        branch,
  input  logic        zero,
  input  logic [15:0] branch_imm,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        halt,
  output logic [29:0] pc_addr,
  output logic [31:0] instr,
  output logic        valid,
  output logic [29:0] pc_plus1,
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [29:0] pc, pc_next;
  logic [29:0] branch_offset;
  logic [29:0] branch_target;
  logic [29:0] jump_addr;
  logic [29:0] jr_word;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // All arithmetic is 30 bits wide, so carries out of bit 29 drop silently.
  assign pc_plus1      = pc + 30'd1;
  assign branch_offset = {{14{branch_imm[15]}}, branch_imm};
  assign branch_target = pc_plus1 + branch_offset;
  assign jump_addr     = {pc[29:26], jump_target};
  assign jr_word       = jr_addr[31:2];

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    unique case (state)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (stall) begin
          pc_next = pc;
        end else if (halt) begin
          state_next = HALTED;
        end else if (jr) begin
          pc_next = jr_word;
        end else if (jump) begin
          pc_next = jump_addr;
        end else if (branch && zero) begin
          pc_next = branch_target;
        end else begin
          pc_next = pc_plus1;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = BOOT;
        pc_next    = RESET_PC;
      end
    endcase
  end

  assign pc_addr = pc;
  assign valid   = (state == RUN);
  assign halted  = (state == HALTED);
  assign instr   = valid ? instr_in : 32'h0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with hand-computed PC values.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] instr_in;
  logic        stall;
  logic        jump;
  logic [25:0] jump_target;
  logic        branch;
  logic        zero;
  logic [15:0] branch_imm;
  logic        jr;
  logic [31:0] jr_addr;
  logic        halt;
  logic [29:0] pc_addr;
  logic [31:0] instr;
  logic        valid;
  logic [29:0] pc_plus1;
  logic        halted;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .instr_in    (instr_in),
    .stall       (stall),
    .jump        (jump),
    .jump_target (jump_target),
    .branch      (branch),
    .zero        (zero),
    .branch_imm  (branch_imm),
    .jr          (jr),
    .jr_addr     (jr_addr),
    .halt        (halt),
    .pc_addr     (pc_addr),
    .instr       (instr),
    .valid       (valid),
    .pc_plus1    (pc_plus1),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic clear_requests();
    stall       = 1'b0;
    jump        = 1'b0;
    jump_target = 26'h0;
    branch      = 1'b0;
    zero        = 1'b0;
    branch_imm  = 16'h0;
    jr          = 1'b0;
    jr_addr     = 32'h0;
    halt        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Redirect the PC to a word address via jr, then drop all requests.
  task automatic go_to(input logic [29:0] target);
    clear_requests();
    jr      = 1'b1;
    jr_addr = {target, 2'b00};
    tick();
    clear_requests();
  endtask

  initial begin
    clear_requests();
    instr_in = 32'hDEAD_BEEF;
    reset    = 1'b1;
    #2;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", 32'(pc_addr), 32'h0);
    check("rst_pc_plus1", 32'(pc_plus1), 32'h1);

    tick();
    reset = 1'b0;
    check("boot_valid", 32'(valid), 32'd0);
    check("boot_pc", 32'(pc_addr), 32'h0);
    check("boot_instr", instr, 32'h0);

    for (int i = 0; i < 4; i++) begin
      tick();
      instr_in = 32'h1000_0000 + 32'(i);
      #1;
      check($sformatf("seq_pc%0d", i), 32'(pc_addr), 32'(i));
      check($sformatf("seq_valid%0d", i), 32'(valid), 32'd1);
      check($sformatf("seq_instr%0d", i), instr, 32'h1000_0000 + 32'(i));
    end

    // Taken branch with negative offset: 0x10 + 1 - 4 = 0xD.
    go_to(30'h10);
    check("jr_to_10", 32'(pc_addr), 32'h10);
    branch = 1'b1; zero = 1'b1; branch_imm = 16'hFFFC;
    tick();
    check("branch_taken", 32'(pc_addr), 32'hD);
    go_to(30'h10);
    branch = 1'b1; zero = 1'b0; branch_imm = 16'hFFFC;
    tick();
    check("branch_not_taken", 32'(pc_addr), 32'h11);

    // Positive branch offset.
    go_to(30'h100);
    branch = 1'b1; zero = 1'b1; branch_imm = 16'h0020;
    tick();
    check("branch_fwd", 32'(pc_addr), 32'h121);

    // Jump beats branch and keeps PC[29:26].
    go_to(30'h0800_0005);
    jump = 1'b1; jump_target = 26'h000_0040; branch = 1'b1; zero = 1'b1;
    branch_imm = 16'h0003;
    tick();
    check("jump_over_branch", 32'(pc_addr), 32'h0800_0040);

    // jr beats jump; low address bits ignored.
    clear_requests();
    jr = 1'b1; jr_addr = 32'h0000_0103; jump = 1'b1; jump_target = 26'h3FF_FFFF;
    tick();
    check("jr_over_jump", 32'(pc_addr), 32'h40);

    clear_requests();
    stall = 1'b1; jr = 1'b1; jr_addr = 32'h0000_0800;
    tick();
    check("stall_over_jr", 32'(pc_addr), 32'h40);
    check("stall_valid", 32'(valid), 32'd1);

    clear_requests();
    stall = 1'b1; halt = 1'b1;
    tick();
    check("stall_over_halt_pc", 32'(pc_addr), 32'h40);
    check("stall_over_halt_halted", 32'(halted), 32'd0);

    // Wrap at the top of the 30-bit space.
    go_to(30'h3FFF_FFFF);
    check("pc_top", 32'(pc_addr), 32'h3FFF_FFFF);
    check("pc_plus1_wrap", 32'(pc_plus1), 32'h0);
    tick();
    check("pc_wrap", 32'(pc_addr), 32'h0);

    // Halt at PC 5; nothing but reset moves it.
    go_to(30'h5);
    halt = 1'b1; jump = 1'b1; jump_target = 26'h0ABC;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("halt_pc%0d", i), 32'(pc_addr), 32'h5);
      check($sformatf("halt_flag%0d", i), 32'(halted), 32'd1);
      check($sformatf("halt_valid%0d", i), 32'(valid), 32'd0);
      tick();
    end
    check("halt_instr", instr, 32'h0);

    #2;
    reset = 1'b1;
    #1;
    check("async_rst_pc", 32'(pc_addr), 32'h0);
    check("async_rst_halted", 32'(halted), 32'd0);
    check("async_rst_valid", 32'(valid), 32'd0);

    // Requests held across BOOT are ignored.
    tick();
    reset = 1'b0;
    jump = 1'b1; jump_target = 26'h55;
    check("boot2_pc", 32'(pc_addr), 32'h0);
    tick();
    check("boot_ignores_jump", 32'(pc_addr), 32'h0);
    check("boot2_run_valid", 32'(valid), 32'd1);
    tick();
    check("run_jump", 32'(pc_addr), 32'h55);

    // Reset mid-RUN discards a pending jr.
    clear_requests();
    jr = 1'b1; jr_addr = 32'h0000_4000;
    #2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_discard_pc", 32'(pc_addr), 32'h0);
    check("rst_discard_valid", 32'(valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, default 30'h0, word address loaded into PC on reset.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-004 instr_in  input  32  instruction word from instruction memory DataOut (combinational read of pc_addr).
REQ-005 stall  input  1  hold PC and state this cycle.
REQ-006 jump  input  1  absolute jump request.
REQ-007 jump_target  input  26  jump word target.
REQ-008 branch  input  1  conditional branch request.
REQ-009 zero  input  1  ALU zero flag; qualifies branch.
REQ-010 branch_imm  input  16  signed word offset.
REQ-011 jr  input  1  register-indirect jump request.
REQ-012 jr_addr  input  32  byte address; bits [31:2] used, [1:0] ignored.
REQ-013 halt  input  1  stop fetching.
REQ-014 pc_addr  output  30  word address to instruction memory Addr; equals PC register.
REQ-015 instr  output  32  instr_in when valid=1, else 32'h0.
REQ-016 valid  output  1  instr is a live instruction this cycle.
REQ-017 pc_plus1  output  30  PC+1 mod 2^30, link value.
REQ-018 halted  output  1  high in HALTED state.

Function
REQ-019 States: BOOT, RUN, HALTED; state and PC are registers, all other outputs combinational from them and inputs.
REQ-020 BOOT: valid=0, PC holds RESET_PC; next cycle -> RUN unconditionally (stall ignored).
REQ-021 RUN: valid=1; next PC chosen by fixed priority, first match wins: stall (hold) > halt (hold, -> HALTED) > jr > jump > branch&&zero > PC+1.
REQ-022 jr: next PC = jr_addr[31:2] truncated to 30 bits.
REQ-023 jump: next PC = {PC[29:26], jump_target}.
REQ-024 branch taken (branch=1 and zero=1): next PC = PC + 1 + sign_extend_30(branch_imm), mod 2^30.
REQ-025 branch=1, zero=0: next PC = PC+1.
REQ-026 All PC arithmetic 30-bit, wraps silently: 30'h3FFFFFFF + 1 = 0.
REQ-027 HALTED: valid=0, halted=1, PC frozen; all inputs except reset ignored; only reset exits.
REQ-028 Simultaneous jr, jump, branch: resolved by REQ-021 priority; no error.
REQ-029 stall with halt asserted: stall wins; halt takes effect on first non-stalled RUN cycle it is still high.
REQ-030 Requests in BOOT are ignored; not queued.
REQ-031 Latency: redirect issued in cycle N appears on pc_addr in cycle N+1; no delay slot.

Reset
REQ-032 reset=1 asynchronously sets PC=RESET_PC, state=BOOT; outputs immediately valid=0, halted=0, instr=0, pc_addr=RESET_PC, pc_plus1=RESET_PC+1.
REQ-033 Reset mid-operation (any state, any cycle phase) discards pending redirect; first cycle after release is BOOT.
REQ-034 Reset deassertion is a synchronous-safe release; first posedge after deassertion moves BOOT -> RUN.

Verification
REQ-035 Reset, release, no requests -> one cycle valid=0 at pc_addr 0, then pc_addr 0,1,2,3 on successive cycles with valid=1 and instr=instr_in.
REQ-036 PC=30'h0000_0010, branch=1, zero=1, branch_imm=16'hFFFC -> next pc_addr 30'h0000_000D; same with zero=0 -> 30'h0000_0011.
REQ-037 PC=30'h0800_0005, jump=1, jump_target=26'h000_0040, branch=1, zero=1 simultaneously -> next pc_addr 30'h0800_0040.
REQ-038 jr=1, jr_addr=32'h0000_0103, jump=1 same cycle -> next pc_addr 30'h0000_0040; stall=1 with jr=1 -> pc_addr unchanged.
REQ-039 PC=30'h3FFF_FFFF, no requests -> next pc_addr 0; halt=1 at PC=5 -> pc_addr stays 5, halted=1, valid=0 for 10 cycles despite jump=1; reset asserted mid-cycle -> pc_addr=0, halted=0 immediately.
